// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 boot-time program loader.
// Holds the halt opcode, header width and loader state encoding.
package mips32_pkg;

  localparam logic [5:0] OPC_HLT = 6'b111111;
  localparam int         HDR_W   = 16;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    DONE,
    ERR
  } ld_state_t;

endpackage

// File: rtl/mips32_byte_packer.sv
// Big-endian 8->32 assembler: the fourth accepted byte completes a word.
// o_word_valid is combinational and coincides with the edge taking that byte.
module mips32_byte_packer (
  input  logic        i_clk,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [23:0] r_shift;
  logic [1:0]  r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_valid) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

  assign o_word_valid = i_valid && (r_cnt == 2'd3);
  assign o_word       = {r_shift, i_byte};

endmodule

// File: rtl/mips32_prog_loader.sv
// Streams a length-prefixed byte image into instruction memory from address 0,
// holding the core halted until the last word has been written.
//
// state  | meaning
// HDR_HI | waiting for header byte N[15:8]
// HDR_LO | waiting for header byte N[7:0]; decides DONE / ERR / DATA
// DATA   | assembling words and writing them at consecutive addresses
// DONE   | image complete, core released (until rst)
// ERR    | header larger than MAX_WORDS, core held (until rst)
module mips32_prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic              no_hlt,
  output logic [ADDR_W:0]   word_count
);
  import mips32_pkg::*;

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  ld_state_t         r_state;
  ld_state_t         w_next;
  logic [7:0]        r_hdr_hi;
  logic [HDR_W-1:0]  r_num;
  logic [ADDR_W:0]   r_word_cnt;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_no_hlt;

  logic              w_xfer;
  logic [HDR_W-1:0]  w_hdr;
  logic              w_pack_valid;
  logic              w_word_valid;
  logic [31:0]       w_word;
  logic              w_last_word;

  assign in_ready     = (r_state == HDR_HI) || (r_state == HDR_LO) || (r_state == DATA);
  assign w_xfer       = in_valid && in_ready;
  assign w_hdr        = {r_hdr_hi, in_data};
  assign w_pack_valid = w_xfer && (r_state == DATA);
  assign w_last_word  = w_word_valid && ((32'(r_word_cnt) + 32'd1) == 32'(r_num));

  mips32_byte_packer u_packer (
    .i_clk        (clk1),
    .i_clear      (rst),
    .i_valid      (w_pack_valid),
    .i_byte       (in_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge clk1) begin
    if (rst) r_state <= HDR_HI;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      HDR_HI: if (w_xfer) w_next = HDR_LO;
      HDR_LO: begin
        if (w_xfer) begin
          if (w_hdr == '0)              w_next = DONE;
          else if (32'(w_hdr) > MAX_W) w_next = ERR;
          else                          w_next = DATA;
        end
      end
      DATA:    if (w_last_word) w_next = DONE;
      default: w_next = r_state;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_hdr_hi    <= '0;
      r_num       <= '0;
      r_word_cnt  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_no_hlt    <= 1'b0;
    end else begin
      r_mem_we <= w_word_valid;
      if (w_xfer && (r_state == HDR_HI)) r_hdr_hi <= in_data;
      if (w_xfer && (r_state == HDR_LO)) r_num    <= w_hdr;
      // Address is the pre-increment count, so the first word lands at 0.
      if (w_word_valid) begin
        r_mem_addr  <= r_word_cnt[ADDR_W-1:0];
        r_mem_wdata <= w_word;
        r_word_cnt  <= r_word_cnt + {{ADDR_W{1'b0}}, 1'b1};
      end
      if (w_last_word) r_no_hlt <= (w_word[31:26] != OPC_HLT);
    end
  end

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign word_count = r_word_cnt;
  assign no_hlt     = r_no_hlt;
  assign load_done  = (r_state == DONE);
  assign load_err   = (r_state == ERR);
  assign cpu_hold   = (r_state != DONE);

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for the program loader: expected writes are queued as words
// are sent and popped by a monitor whenever the loader strobes mem_we.
module tb_mips32_prog_loader;

  localparam int ADDR_W = 10;

  logic              clk1 = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic              no_hlt;
  logic [ADDR_W:0]   word_count;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t sb_q[$];
  int  errors = 0;
  int  checks = 0;
  int  n_we = 0;
  bit  prev_we = 1'b0;

  logic [31:0] img [0:8] = '{32'h2801000a, 32'h28020014, 32'h28030019,
                             32'h0ce77800, 32'h0ce77800, 32'h00222000,
                             32'h0ce77800, 32'h00832800, 32'hfc000000};

  mips32_prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(1024)) dut (
    .clk1       (clk1),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .no_hlt     (no_hlt),
    .word_count (word_count)
  );

  always #5 clk1 = ~clk1;

  always @(negedge clk1) begin
    if (mem_we === 1'b1) begin
      wr_t exp_w;
      n_we++;
      checks++;
      assert (prev_we == 1'b0) else begin
        errors++;
        $error("FAIL we_pulse: observed=mem_we high two cycles expected=one-cycle strobe");
      end
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL stray_write: observed write addr=%0d data=%h expected=no write", mem_addr, mem_wdata);
      end
      if (sb_q.size() != 0) begin
        exp_w = sb_q.pop_front();
        checks++;
        assert (mem_addr === exp_w.addr) else begin
          errors++;
          $error("FAIL wr_addr: observed=%0d expected=%0d", mem_addr, exp_w.addr);
        end
        checks++;
        assert (mem_wdata === exp_w.data) else begin
          errors++;
          $error("FAIL wr_data: observed=%h expected=%h", mem_wdata, exp_w.data);
        end
      end
    end
    prev_we = (mem_we === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gmax);
    int g;
    g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
    in_valid = 1'b0;
    repeat (g) tick();
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] n, input int gmax);
    send_byte(n[15:8], gmax);
    send_byte(n[7:0], gmax);
  endtask

  task automatic send_word(input logic [31:0] w, input int addr, input int gmax);
    sb_q.push_back('{addr: ADDR_W'(addr), data: w});
    send_byte(w[31:24], gmax);
    send_byte(w[23:16], gmax);
    send_byte(w[15:8], gmax);
    send_byte(w[7:0], gmax);
  endtask

  task automatic check_full_image(input string tag, input int n_we0);
    chk({tag, "_done"},  32'(load_done), 32'd1);
    chk({tag, "_hold"},  32'(cpu_hold), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    repeat (3) tick();
    chk({tag, "_count"}, 32'(word_count), 32'd9);
    chk({tag, "_nohlt"}, 32'(no_hlt), 32'd0);
    chk({tag, "_nwe"},   32'(n_we - n_we0), 32'd9);
    chk({tag, "_sbq"},   32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int n0;

    // Reset values
    rst = 1'b1;
    tick();
    tick();
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_we",    32'(mem_we), 32'd0);
    chk("rst_addr",  32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_hold",  32'(cpu_hold), 32'd1);
    chk("rst_done",  32'(load_done), 32'd0);
    chk("rst_err",   32'(load_err), 32'd0);
    chk("rst_nohlt", 32'(no_hlt), 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    rst = 1'b0;

    // Full 9-word image, back to back
    n0 = n_we;
    send_hdr(16'h0009, 0);
    chk("img_hold_hdr", 32'(cpu_hold), 32'd1);
    for (int i = 0; i < 9; i++) begin
      send_word(img[i], i, 0);
      if (i < 8) chk("img_hold_mid", 32'(cpu_hold), 32'd1);
    end
    check_full_image("img", n0);

    // Same image with random gaps in in_valid
    do_reset();
    n0 = n_we;
    send_hdr(16'h0009, 5);
    for (int i = 0; i < 9; i++) send_word(img[i], i, 5);
    check_full_image("gap", n0);

    // Empty image
    do_reset();
    n0 = n_we;
    send_byte(8'h00, 0);
    chk("n0_done_early", 32'(load_done), 32'd0);
    send_byte(8'h00, 0);
    chk("n0_done",  32'(load_done), 32'd1);
    chk("n0_hold",  32'(cpu_hold), 32'd0);
    chk("n0_ready", 32'(in_ready), 32'd0);
    repeat (3) tick();
    chk("n0_nwe",   32'(n_we - n0), 32'd0);
    chk("n0_count", 32'(word_count), 32'd0);

    // Exactly MAX_WORDS is accepted
    do_reset();
    send_hdr(16'h0400, 0);
    chk("max_err",   32'(load_err), 32'd0);
    chk("max_ready", 32'(in_ready), 32'd1);

    // One more than MAX_WORDS is rejected and further bytes ignored
    do_reset();
    n0 = n_we;
    send_hdr(16'h0401, 0);
    chk("ovf_err",   32'(load_err), 32'd1);
    chk("ovf_hold",  32'(cpu_hold), 32'd1);
    chk("ovf_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 8; i++) send_byte(8'(i * 37), 0);
    repeat (2) tick();
    chk("ovf_ready_after", 32'(in_ready), 32'd0);
    chk("ovf_done",  32'(load_done), 32'd0);
    chk("ovf_count", 32'(word_count), 32'd0);
    chk("ovf_nwe",   32'(n_we - n0), 32'd0);

    // Image not ending in HLT
    do_reset();
    n0 = n_we;
    send_hdr(16'h0002, 0);
    chk("nh_ready", 32'(in_ready), 32'd1);
    send_word(32'h00222000, 0, 0);
    send_word(32'h0ce77800, 1, 0);
    chk("nh_done", 32'(load_done), 32'd1);
    repeat (2) tick();
    chk("nh_nohlt", 32'(no_hlt), 32'd1);
    chk("nh_count", 32'(word_count), 32'd2);
    chk("nh_nwe",   32'(n_we - n0), 32'd2);

    // Reset mid-word 3 (with a byte offered on the reset edge), then reload
    do_reset();
    n0 = n_we;
    send_hdr(16'h0009, 0);
    for (int i = 0; i < 3; i++) send_word(img[i], i, 0);
    send_byte(img[3][31:24], 0);
    send_byte(img[3][23:16], 0);
    in_valid = 1'b1;
    in_data  = img[3][15:8];
    rst      = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_count", 32'(word_count), 32'd0);
    chk("mid_ready", 32'(in_ready), 32'd1);
    chk("mid_hold",  32'(cpu_hold), 32'd1);
    chk("mid_nwe",   32'(n_we - n0), 32'd3);
    n0 = n_we;
    send_hdr(16'h0009, 0);
    for (int i = 0; i < 9; i++) send_word(img[i], i, 0);
    check_full_image("reload", n0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
